// File: rtl/lane_register.sv
// lane_register: LANES x LANE_WIDTH pointer/counter register with per-lane loads, mirrored
// tri-state bus drive and a lane-serial ripple step engine enabled by LANE_REGISTER_STEP_EN.
package lane_register_pkg;
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    READ     = 2'd1,
    WRITE    = 2'd2,
    SWRITENC = 2'd3
  } reg_op_t;
endpackage

module lane_register
  import lane_register_pkg::*;
#(
  parameter int LANE_WIDTH = 4,
  parameter int LANES      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  reg_op_t [LANES-1:0]         lane_op,
  input  logic [LANES-1:0]            bus_b_sel,
  input  logic [LANES*LANE_WIDTH-1:0] bus_in,
  input  logic [LANE_WIDTH-1:0]       bus_b_in,
  input  logic                        step_req,
  input  logic                        step_dir,
  output logic                        step_busy,
  output logic                        step_done,
  output logic                        step_carry,
  output logic                        step_abort,
  output logic [LANES*LANE_WIDTH-1:0] bus_out,
  output logic [LANES*LANE_WIDTH-1:0] always_bus_out
);

  localparam int W = LANES * LANE_WIDTH;

  logic [W-1:0]          state_q;
  logic [W-1:0]          state_d;
  logic [LANES-1:0]      load_read;
  logic                  any_load;
  logic [LANES-1:0]      step_lane_en;
  logic [LANE_WIDTH-1:0] step_lane_val;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      load_read[i] = (lane_op[i] == READ);
    end
  end

  assign any_load = |(load_read | bus_b_sel);

  // Per-lane priority: main bus load, then narrow bus load, then the step engine.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    for (int i = 0; i < LANES; i++) begin
      if (load_read[i]) begin
        state_d[i*LANE_WIDTH +: LANE_WIDTH] = bus_in[i*LANE_WIDTH +: LANE_WIDTH];
      end else if (bus_b_sel[i]) begin
        state_d[i*LANE_WIDTH +: LANE_WIDTH] = bus_b_in;
      end else if (step_lane_en[i]) begin
        state_d[i*LANE_WIDTH +: LANE_WIDTH] = step_lane_val;
      end
    end
  end

  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign always_bus_out = state_q;

  // Bus drive: WRITE/SWRITENC lanes drive themselves; idle lanes mirror the lowest WRITE lane.
  logic [LANES-1:0]      drive_en;
  logic [W-1:0]          drive_val;
  logic [LANE_WIDTH-1:0] mirror_val;
  logic                  any_write;

  always_comb begin
    any_write  = 1'b0;
    mirror_val = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_op[i] == WRITE) begin
        any_write  = 1'b1;
        mirror_val = state_q[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (lane_op[i] == WRITE || lane_op[i] == SWRITENC) begin
        drive_en[i]                           = 1'b1;
        drive_val[i*LANE_WIDTH +: LANE_WIDTH] = state_q[i*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        drive_en[i]                           = (lane_op[i] == NONE) && any_write;
        drive_val[i*LANE_WIDTH +: LANE_WIDTH] = mirror_val;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bus
    assign bus_out[g*LANE_WIDTH +: LANE_WIDTH] =
      drive_en[g] ? drive_val[g*LANE_WIDTH +: LANE_WIDTH] : {LANE_WIDTH{1'bz}};
  end

`ifdef LANE_REGISTER_STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RIPPLE, S_DONE, S_ABORT} step_state_t;

  localparam int              IDX_W    = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  step_state_t           step_q, step_d;
  logic [IDX_W-1:0]      idx_q, idx_d, cur_idx;
  logic                  dir_q, dir_d;
  logic                  carry_q, carry_d;
  logic                  cur_dir;
  logic                  lane_cout;
  logic [LANE_WIDTH-1:0] cur_lane;

  always_comb begin
    step_d        = step_q;
    idx_d         = idx_q;
    dir_d         = dir_q;
    carry_d       = carry_q;
    step_lane_en  = '0;
    cur_idx       = (step_q == S_RIPPLE) ? idx_q : '0;
    cur_dir       = (step_q == S_RIPPLE) ? dir_q : step_dir;
    cur_lane      = state_q[int'(cur_idx)*LANE_WIDTH +: LANE_WIDTH];
    lane_cout     = cur_dir ? (cur_lane == '0) : (cur_lane == '1);
    step_lane_val = cur_dir ? cur_lane - LANE_WIDTH'(1) : cur_lane + LANE_WIDTH'(1);

    case (step_q)
      S_RIPPLE: begin
        if (any_load) begin
          step_d = S_ABORT;
        end else begin
          step_lane_en[cur_idx] = 1'b1;
          if (!lane_cout || idx_q == LAST_IDX) begin
            step_d  = S_DONE;
            carry_d = lane_cout;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        // A step in ripple always carries in 1, so only the direction needs latching.
        if (step_req && !any_load) begin
          dir_d           = step_dir;
          step_lane_en[0] = 1'b1;
          carry_d         = 1'b0;
          if (lane_cout) begin
            step_d = S_RIPPLE;
            idx_d  = IDX_W'(1);
          end else begin
            step_d = S_DONE;
          end
        end else begin
          step_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      step_q  <= S_IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      carry_q <= carry_d;
    end
  end

  assign step_busy  = (step_q == S_RIPPLE);
  assign step_done  = (step_q == S_DONE);
  assign step_abort = (step_q == S_ABORT);
  assign step_carry = (step_q == S_DONE) && carry_q;
`else
  logic unused_step_inputs;

  assign unused_step_inputs = ^{step_req, step_dir, any_load};
  assign step_lane_en       = '0;
  assign step_lane_val      = '0;
  assign step_busy          = 1'b0;
  assign step_done          = 1'b0;
  assign step_abort         = 1'b0;
  assign step_carry         = 1'b0;
`endif

endmodule

// File: tb/tb_lane_register.sv
// Scoreboard bench for lane_register (LANES=3, LANE_WIDTH=4); step expectations follow
// LANE_REGISTER_STEP_EN, otherwise the step outputs are expected to stay 0.
module tb_lane_register;
  import lane_register_pkg::*;

  localparam int LW = 4;
  localparam int LN = 3;
  localparam int W  = LW * LN;

  typedef reg_op_t [LN-1:0] ops_t;

  typedef struct {
    logic [W-1:0] state;
    logic [W-1:0] bus;
    logic [W-1:0] bus_mask;
    logic         busy;
    logic         done;
    logic         carry;
    logic         abort;
    int           cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  ops_t          lane_op;
  logic [LN-1:0] bus_b_sel;
  logic [W-1:0]  bus_in;
  logic [LW-1:0] bus_b_in;
  logic          step_req;
  logic          step_dir;
  logic          step_busy, step_done, step_carry, step_abort;
  wire  [W-1:0]  bus_out;
  logic [W-1:0]  always_bus_out;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: whole-register value plus a pending step described by its final target.
  logic [W-1:0] m_val = '0;
  logic [W-1:0] m_target = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_abort = 1'b0, m_carry = 1'b0, m_wrap = 1'b0;
  int           m_k = 0, m_n = 0;

  lane_register #(.LANE_WIDTH(LW), .LANES(LN)) dut (
    .clk            (clk),
    .rst            (rst),
    .lane_op        (lane_op),
    .bus_b_sel      (bus_b_sel),
    .bus_in         (bus_in),
    .bus_b_in       (bus_b_in),
    .step_req       (step_req),
    .step_dir       (step_dir),
    .step_busy      (step_busy),
    .step_done      (step_done),
    .step_carry     (step_carry),
    .step_abort     (step_abort),
    .bus_out        (bus_out),
    .always_bus_out (always_bus_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want,
                       input int c);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, want);
    end
  endtask

  function automatic ops_t mk_ops(input reg_op_t l0, input reg_op_t l1, input reg_op_t l2);
    ops_t o;
    o[0] = l0;
    o[1] = l1;
    o[2] = l2;
    return o;
  endfunction

  function automatic bit lane_carries(input logic [LW-1:0] v, input logic d);
    return d ? (v == '0) : (v == '1);
  endfunction

  // Drive one cycle of inputs, advance the model across the falling edge, queue the expectation.
  task automatic drive_cycle(input logic r, input ops_t ops, input logic [LN-1:0] bsel,
                             input logic [LW-1:0] bb, input logic [W-1:0] bi,
                             input logic req, input logic dir);
    logic [LN-1:0] loaded;
    exp_t          e;
    int            wr_lane;
    rst = r; lane_op = ops; bus_b_sel = bsel; bus_b_in = bb; bus_in = bi;
    step_req = req; step_dir = dir;
    loaded = '0;
    if (r) begin
      m_val = '0; m_busy = 0; m_done = 0; m_abort = 0; m_carry = 0;
    end else begin
      for (int i = 0; i < LN; i++) begin
        if (ops[i] == READ) begin
          m_val[i*LW +: LW] = bi[i*LW +: LW];
          loaded[i] = 1'b1;
        end else if (bsel[i]) begin
          m_val[i*LW +: LW] = bb;
          loaded[i] = 1'b1;
        end
      end
      m_done = 0; m_abort = 0; m_carry = 0;
`ifdef LANE_REGISTER_STEP_EN
      if (m_busy) begin
        if (loaded != '0) begin
          m_busy  = 0;
          m_abort = 1;
        end else begin
          m_val[m_n*LW +: LW] = m_target[m_n*LW +: LW];
          m_n++;
          if (m_n == m_k) begin
            m_busy = 0; m_done = 1; m_carry = m_wrap;
          end
        end
      end else if (req && loaded == '0) begin
        m_target = dir ? m_val - W'(1) : m_val + W'(1);
        m_wrap   = dir ? (m_val == '0) : (m_val == '1);
        m_k = 1;
        while (m_k < LN && lane_carries(m_val[(m_k-1)*LW +: LW], dir)) m_k++;
        m_val[0 +: LW] = m_target[0 +: LW];
        m_n = 1;
        if (m_n == m_k) begin
          m_done = 1; m_carry = m_wrap;
        end else begin
          m_busy = 1;
        end
      end
`endif
    end
    wr_lane = -1;
    for (int i = 0; i < LN; i++) if (ops[i] == WRITE && wr_lane < 0) wr_lane = i;
    e.bus = '0; e.bus_mask = '0;
    for (int i = 0; i < LN; i++) begin
      if (ops[i] == WRITE || ops[i] == SWRITENC) begin
        e.bus[i*LW +: LW] = m_val[i*LW +: LW];
        e.bus_mask[i*LW +: LW] = '1;
      end else if (ops[i] == NONE && wr_lane >= 0) begin
        e.bus[i*LW +: LW] = m_val[wr_lane*LW +: LW];
        e.bus_mask[i*LW +: LW] = '1;
      end
    end
    e.state = m_val; e.busy = m_busy; e.done = m_done; e.carry = m_carry; e.abort = m_abort;
    e.cyc = cyc;
    sb_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, mk_ops(NONE, NONE, NONE), '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic load_all(input logic [W-1:0] v);
    drive_cycle(1'b0, mk_ops(READ, READ, READ), '0, '0, v, 1'b0, 1'b0);
  endtask

  task automatic step(input logic dir);
    drive_cycle(1'b0, mk_ops(NONE, NONE, NONE), '0, '0, '0, 1'b1, dir);
  endtask

  function automatic reg_op_t rand_op(input bit allow_read);
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return NONE;
    if (r < 14) return allow_read ? READ : NONE;
    if (r < 17) return WRITE;
    return SWRITENC;
  endfunction

  // Monitor: outputs settle after the falling edge and are sampled on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("always_bus_out", always_bus_out, e.state, e.cyc);
        if (e.bus_mask != '0) check("bus_out", bus_out & e.bus_mask, e.bus & e.bus_mask, e.cyc);
        check("step_busy", W'(step_busy), W'(e.busy), e.cyc);
        check("step_done", W'(step_done), W'(e.done), e.cyc);
        check("step_carry", W'(step_carry), W'(e.carry), e.cyc);
        check("step_abort", W'(step_abort), W'(e.abort), e.cyc);
      end
    end
  end

  initial begin
    logic [W-1:0] pick [6];
    ops_t         ops;
    logic [LN-1:0] bsel;
    bit           quiet;
    rst = 1'b1; lane_op = mk_ops(NONE, NONE, NONE); bus_b_sel = '0; bus_in = '0;
    bus_b_in = '0; step_req = 1'b0; step_dir = 1'b0;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, mk_ops(NONE, NONE, NONE), '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, mk_ops(NONE, NONE, NONE), '0, '0, '0, 1'b1, 1'b0);

    // Lane loads and priority.
    drive_cycle(1'b0, mk_ops(NONE, READ, READ), 3'b000, 4'h0, 12'hABC, 1'b0, 1'b0);
    drive_cycle(1'b0, mk_ops(NONE, READ, READ), 3'b001, 4'h5, 12'hABC, 1'b0, 1'b0);
    drive_cycle(1'b0, mk_ops(READ, NONE, NONE), 3'b001, 4'h5, 12'h007, 1'b0, 1'b0);

    // Mirroring.
    load_all(12'h3C7);
    drive_cycle(1'b0, mk_ops(NONE, WRITE, SWRITENC), '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, mk_ops(NONE, SWRITENC, NONE), '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, mk_ops(WRITE, NONE, WRITE), '0, '0, '0, 1'b0, 1'b0);

    // Increment ripple, then decrement wrap.
    load_all(12'h0FF);
    step(1'b0); idle(); idle(); idle(); idle();
    load_all(12'h000);
    step(1'b1); idle(); idle(); idle(); idle();

    // Abort by a narrow load mid-ripple, then reset mid-ripple.
    load_all(12'h0FF);
    step(1'b0);
    drive_cycle(1'b0, mk_ops(NONE, NONE, NONE), 3'b100, 4'h9, '0, 1'b0, 1'b0);
    idle(); idle();
    load_all(12'h0FF);
    step(1'b0);
    drive_cycle(1'b1, mk_ops(NONE, NONE, NONE), '0, '0, '0, 1'b1, 1'b0);
    idle(); idle();

    // Back-to-back accept while done, and a request ignored during ripple.
    load_all(12'h00E);
    step(1'b0); step(1'b0); step(1'b1); step(1'b1); idle(); idle(); idle();

    // Randomised traffic biased toward values that carry across lanes.
    pick[0] = 12'h000; pick[1] = 12'hFFF; pick[2] = 12'h0FF;
    pick[3] = 12'hF00; pick[4] = 12'h0F0; pick[5] = 12'h00F;
    for (int n = 0; n < 400; n++) begin
      quiet = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < LN; i++) ops[i] = rand_op(!quiet);
      bsel = '0;
      if (!quiet) for (int i = 0; i < LN; i++) bsel[i] = ($urandom_range(0, 9) == 0);
      drive_cycle(($urandom_range(0, 49) == 0), ops, bsel, 4'($urandom),
                  ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 5)] : 12'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
    idle();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
